// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// FSM state encoding is fixed because debug displays decode state_o directly.
package pc_seq_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_CNT_W  = 16;
    localparam int STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_HALT  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge pulse generator with asynchronous active-low reset.
// The first clock after reset only arms the detector, so a level held high through reset makes no pulse.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_pulse
);

    logic r_armed;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_prev  <= i_sig;
            r_pulse <= i_sig & ~r_prev & r_armed;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: run/step/stop/halt/clear control, jump/branch next-PC and retired counter.
// Optional breakpoint support is enabled with the PC_SEQ_BREAKPOINT_EN macro.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int                CNT_W      = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_i,
    input  logic               run_i,
    input  logic               step_i,
    input  logic               stop_i,
    input  logic               clear_i,
    input  logic               halt_i,
    input  logic               jump_i,
    input  logic [ADDR_W-1:0]  jump_addr_i,
    input  logic               branch_i,
    input  logic               zero_i,
    input  logic [ADDR_W-1:0]  br_off_i,
    input  logic [ADDR_W-1:0]  bp_addr_i,
    input  logic               bp_en_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [ADDR_W-1:0]  pc_plus1_o,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   retired_o,
    output logic               halted_o,
    output logic               at_bp_o
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [CNT_W-1:0]    r_retired;
    logic                r_halted;
    logic                r_at_bp;
    logic                w_run_edge;
    logic                w_step_edge;
    logic                w_advance;
    logic                w_bp_hit;
    logic [ADDR_W-1:0]   w_pc_plus1;
    logic [ADDR_W-1:0]   w_next_pc;

    edge_detect u_run_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sig   (run_i),
        .o_pulse (w_run_edge)
    );

    edge_detect u_step_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sig   (step_i),
        .o_pulse (w_step_edge)
    );

    // Address arithmetic wraps naturally at ADDR_W bits.
    assign w_pc_plus1 = r_pc + ADDR_W'(1);
    assign w_next_pc  = jump_i              ? jump_addr_i :
                        (branch_i & zero_i) ? (w_pc_plus1 + br_off_i) :
                                              w_pc_plus1;

`ifdef PC_SEQ_BREAKPOINT_EN
    assign w_bp_hit = bp_en_i && (w_next_pc == bp_addr_i);
`else
    logic w_unused_bp;
    assign w_unused_bp = &{1'b0, bp_addr_i, bp_en_i};
    assign w_bp_hit    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        if (clear_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_BREAK: begin
                    if (w_run_edge) begin
                        w_state_nxt = ST_RUN;
                    end else if (w_step_edge) begin
                        w_state_nxt = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (stop_i) begin
                        w_state_nxt = ST_IDLE;
                    end else if (tick_i) begin
                        if (halt_i) begin
                            w_state_nxt = ST_HALT;
                        end else begin
                            w_advance = 1'b1;
                            if (w_bp_hit) begin
                                w_state_nxt = ST_BREAK;
                            end
                        end
                    end
                end
                ST_STEP: begin
                    if (stop_i) begin
                        w_state_nxt = ST_IDLE;
                    end else if (tick_i) begin
                        if (halt_i) begin
                            w_state_nxt = ST_HALT;
                        end else begin
                            w_advance   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_HALT: begin
                    w_state_nxt = ST_HALT;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_ADDR;
            r_retired <= '0;
            r_halted  <= 1'b0;
            r_at_bp   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            // Decode the next state so the flags line up with state_o.
            r_halted <= (w_state_nxt == ST_HALT);
            r_at_bp  <= (w_state_nxt == ST_BREAK);
            if (clear_i) begin
                r_pc      <= RESET_ADDR;
                r_retired <= '0;
            end else if (w_advance) begin
                r_pc <= w_next_pc;
                if (r_retired != {CNT_W{1'b1}}) begin
                    r_retired <= r_retired + CNT_W'(1);
                end
            end
        end
    end

    assign pc_o       = r_pc;
    assign pc_plus1_o = w_pc_plus1;
    assign state_o    = r_state;
    assign retired_o  = r_retired;
    assign halted_o   = r_halted;
    assign at_bp_o    = r_at_bp;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer; expected PCs are queued when a tick is driven and popped after the edge.
// Breakpoint scenarios follow the PC_SEQ_BREAKPOINT_EN macro.
module tb_pc_sequencer;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              tick_i;
    logic              run_i;
    logic              step_i;
    logic              stop_i;
    logic              clear_i;
    logic              halt_i;
    logic              jump_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              branch_i;
    logic              zero_i;
    logic [ADDR_W-1:0] br_off_i;
    logic [ADDR_W-1:0] bp_addr_i;
    logic              bp_en_i;
    logic [ADDR_W-1:0] pc_o;
    logic [ADDR_W-1:0] pc_plus1_o;
    logic [2:0]        state_o;
    logic [CNT_W-1:0]  retired_o;
    logic              halted_o;
    logic              at_bp_o;

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] m_pc;
    logic [CNT_W-1:0]  m_ret;
    int                n_checks;
    int                n_pass;

    pc_sequencer #(
        .ADDR_W     (ADDR_W),
        .RESET_ADDR (8'h00),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_i      (tick_i),
        .run_i       (run_i),
        .step_i      (step_i),
        .stop_i      (stop_i),
        .clear_i     (clear_i),
        .halt_i      (halt_i),
        .jump_i      (jump_i),
        .jump_addr_i (jump_addr_i),
        .branch_i    (branch_i),
        .zero_i      (zero_i),
        .br_off_i    (br_off_i),
        .bp_addr_i   (bp_addr_i),
        .bp_en_i     (bp_en_i),
        .pc_o        (pc_o),
        .pc_plus1_o  (pc_plus1_o),
        .state_o     (state_o),
        .retired_o   (retired_o),
        .halted_o    (halted_o),
        .at_bp_o     (at_bp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] model_next();
        logic [ADDR_W-1:0] p1;
        p1 = m_pc + 8'd1;
        if (jump_i) return jump_addr_i;
        if (branch_i && zero_i) return p1 + br_off_i;
        return p1;
    endfunction

    // Drive one tick; adv says whether the sequencer should retire an instruction on it.
    task automatic drive_tick(input bit adv);
        logic [ADDR_W-1:0] e;
        e = adv ? model_next() : m_pc;
        if (adv) begin
            m_pc = e;
            if (m_ret != {CNT_W{1'b1}}) m_ret = m_ret + 1'b1;
        end
        exp_q.push_back(e);
        tick_i = 1'b1;
        clk_n(1);
        tick_i = 1'b0;
    endtask

    task automatic pulse_run();
        run_i = 1'b1;
        clk_n(1);
        run_i = 1'b0;
        clk_n(1);
    endtask

    task automatic pulse_step();
        step_i = 1'b1;
        clk_n(1);
        step_i = 1'b0;
        clk_n(1);
    endtask

    task automatic do_stop();
        stop_i = 1'b1;
        clk_n(1);
        stop_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [ADDR_W-1:0] e;
        rst_n = 1'b0;
        run_i = 1'b1;
        clk_n(3);
        n_checks++; if (pc_o !== 8'h00) $display("FAIL reset_pc got=%0h exp=0", pc_o); else n_pass++;
        n_checks++; if (state_o !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state_o); else n_pass++;
        n_checks++; if (retired_o !== '0) $display("FAIL reset_retired got=%0d exp=0", retired_o); else n_pass++;
        n_checks++; if (halted_o !== 1'b0 || at_bp_o !== 1'b0)
            $display("FAIL reset_flags got=%b%b exp=00", halted_o, at_bp_o); else n_pass++;
        e = 8'h01;
        n_checks++; if (pc_plus1_o !== e) $display("FAIL reset_pc_plus1 got=%0h exp=%0h", pc_plus1_o, e); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        clk_n(3);
        n_checks++; if (state_o !== 3'd0) $display("FAIL held_run_no_edge got=%0d exp=0", state_o); else n_pass++;
        run_i = 1'b0;
        clk_n(2);
        m_pc  = 8'h00;
        m_ret = '0;
    endtask

    task automatic test_run();
        logic [ADDR_W-1:0] e;
        pulse_run();
        n_checks++; if (state_o !== 3'd1) $display("FAIL run_enter got=%0d exp=1", state_o); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive_tick(1'b1);
            e = exp_q.pop_front();
            n_checks++; if (pc_o !== e) $display("FAIL run_pc[%0d] got=%0h exp=%0h", i, pc_o, e); else n_pass++;
        end
        n_checks++; if (retired_o !== m_ret) $display("FAIL run_retired got=%0d exp=%0d", retired_o, m_ret); else n_pass++;
        n_checks++; if (state_o !== 3'd1) $display("FAIL run_state got=%0d exp=1", state_o); else n_pass++;
        clk_n(2);
        n_checks++; if (pc_o !== m_pc) $display("FAIL run_no_tick_hold got=%0h exp=%0h", pc_o, m_pc); else n_pass++;
    endtask

    task automatic test_step();
        logic [ADDR_W-1:0] e;
        jump_i      = 1'b1;
        jump_addr_i = 8'h05;
        drive_tick(1'b1);
        jump_i = 1'b0;
        e = exp_q.pop_front();
        n_checks++; if (pc_o !== e) $display("FAIL jump_to5 got=%0h exp=%0h", pc_o, e); else n_pass++;
        do_stop();
        n_checks++; if (state_o !== 3'd0) $display("FAIL stop_idle got=%0d exp=0", state_o); else n_pass++;
        pulse_step();
        n_checks++; if (state_o !== 3'd2) $display("FAIL step_enter got=%0d exp=2", state_o); else n_pass++;
        drive_tick(1'b1);
        e = exp_q.pop_front();
        n_checks++; if (pc_o !== e) $display("FAIL step_pc got=%0h exp=%0h", pc_o, e); else n_pass++;
        n_checks++; if (state_o !== 3'd0) $display("FAIL step_back_idle got=%0d exp=0", state_o); else n_pass++;
        drive_tick(1'b0);
        e = exp_q.pop_front();
        n_checks++; if (pc_o !== e) $display("FAIL step_second_tick got=%0h exp=%0h", pc_o, e); else n_pass++;
        n_checks++; if (retired_o !== m_ret) $display("FAIL step_retired got=%0d exp=%0d", retired_o, m_ret); else n_pass++;
    endtask

    task automatic test_branch_wrap();
        logic [ADDR_W-1:0] e;
        pulse_run();
        jump_i = 1'b1; jump_addr_i = 8'h10;
        drive_tick(1'b1); void'(exp_q.pop_front());
        jump_i = 1'b0; branch_i = 1'b1; zero_i = 1'b1; br_off_i = 8'hFC;
        drive_tick(1'b1);
        e = exp_q.pop_front();
        n_checks++; if (pc_o !== e || e !== 8'h0D) $display("FAIL branch_taken got=%0h exp=%0h", pc_o, e); else n_pass++;
        branch_i = 1'b0; jump_i = 1'b1; jump_addr_i = 8'h10;
        drive_tick(1'b1); void'(exp_q.pop_front());
        jump_i = 1'b0; branch_i = 1'b1; zero_i = 1'b0;
        drive_tick(1'b1);
        e = exp_q.pop_front();
        n_checks++; if (pc_o !== e || e !== 8'h11) $display("FAIL branch_not_taken got=%0h exp=%0h", pc_o, e); else n_pass++;
        branch_i = 1'b0; jump_i = 1'b1; jump_addr_i = 8'hFF;
        drive_tick(1'b1); void'(exp_q.pop_front());
        e = 8'h00;
        n_checks++; if (pc_plus1_o !== e) $display("FAIL pc_plus1_wrap got=%0h exp=%0h", pc_plus1_o, e); else n_pass++;
        jump_i = 1'b0;
        drive_tick(1'b1);
        e = exp_q.pop_front();
        n_checks++; if (pc_o !== e || e !== 8'h00) $display("FAIL pc_wrap got=%0h exp=%0h", pc_o, e); else n_pass++;
        jump_i = 1'b1; jump_addr_i = 8'h40;
        drive_tick(1'b1);
        jump_i = 1'b0;
        e = exp_q.pop_front();
        n_checks++; if (pc_o !== e || e !== 8'h40) $display("FAIL jump_abs got=%0h exp=%0h", pc_o, e); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] e;
        for (int i = 0; i < 8; i++) begin
            jump_i      = ($urandom_range(0, 3) == 0);
            jump_addr_i = 8'($urandom_range(0, 255));
            branch_i    = $urandom_range(0, 1) == 1;
            zero_i      = $urandom_range(0, 1) == 1;
            br_off_i    = 8'($urandom_range(0, 255));
            e = model_next();
            m_pc = e;
            if (m_ret != {CNT_W{1'b1}}) m_ret = m_ret + 1'b1;
            exp_q.push_back(e);
            tick_i = 1'b1;
            clk_n(1);
            e = exp_q.pop_front();
            n_checks++; if (pc_o !== e) $display("FAIL b2b_pc[%0d] got=%0h exp=%0h", i, pc_o, e); else n_pass++;
        end
        tick_i = 1'b0; jump_i = 1'b0; branch_i = 1'b0; zero_i = 1'b0;
        n_checks++; if (retired_o !== m_ret || m_ret !== 4'hF)
            $display("FAIL retired_saturate got=%0d exp=%0d", retired_o, m_ret); else n_pass++;
    endtask

    task automatic test_halt_clear();
        logic [ADDR_W-1:0] e;
        halt_i = 1'b1;
        drive_tick(1'b0);
        halt_i = 1'b0;
        e = exp_q.pop_front();
        n_checks++; if (pc_o !== e) $display("FAIL halt_pc_hold got=%0h exp=%0h", pc_o, e); else n_pass++;
        n_checks++; if (state_o !== 3'd3 || halted_o !== 1'b1)
            $display("FAIL halt_enter state=%0d halted=%b exp=3/1", state_o, halted_o); else n_pass++;
        pulse_run();
        pulse_step();
        drive_tick(1'b0);
        e = exp_q.pop_front();
        n_checks++; if (state_o !== 3'd3 || pc_o !== e)
            $display("FAIL halt_sticky state=%0d pc=%0h exp=3/%0h", state_o, pc_o, e); else n_pass++;
        clear_i = 1'b1;
        clk_n(1);
        clear_i = 1'b0;
        m_pc = 8'h00; m_ret = '0;
        n_checks++; if (pc_o !== 8'h00 || retired_o !== '0)
            $display("FAIL clear_regs pc=%0h ret=%0d exp=0/0", pc_o, retired_o); else n_pass++;
        n_checks++; if (state_o !== 3'd0 || halted_o !== 1'b0)
            $display("FAIL clear_state state=%0d halted=%b exp=0/0", state_o, halted_o); else n_pass++;
    endtask

    task automatic test_stop_tick();
        logic [ADDR_W-1:0] e;
        pulse_run();
        drive_tick(1'b1); void'(exp_q.pop_front());
        stop_i = 1'b1;
        drive_tick(1'b0);
        stop_i = 1'b0;
        e = exp_q.pop_front();
        n_checks++; if (pc_o !== e || state_o !== 3'd0)
            $display("FAIL stop_beats_tick pc=%0h state=%0d exp=%0h/0", pc_o, state_o, e); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        pulse_run();
        drive_tick(1'b1); void'(exp_q.pop_front());
        drive_tick(1'b1); void'(exp_q.pop_front());
        rst_n = 1'b0;
        #1;
        n_checks++; if (pc_o !== 8'h00 || state_o !== 3'd0 || retired_o !== '0)
            $display("FAIL async_reset pc=%0h state=%0d ret=%0d exp=0/0/0", pc_o, state_o, retired_o); else n_pass++;
        clk_n(2);
        rst_n = 1'b1;
        clk_n(2);
        m_pc = 8'h00; m_ret = '0;
    endtask

    task automatic test_breakpoint();
        logic [ADDR_W-1:0] e;
        bp_addr_i = 8'h04;
        bp_en_i   = 1'b1;
        pulse_run();
        for (int i = 0; i < 4; i++) begin
            drive_tick(1'b1);
            e = exp_q.pop_front();
            n_checks++; if (pc_o !== e) $display("FAIL bp_run_pc[%0d] got=%0h exp=%0h", i, pc_o, e); else n_pass++;
        end
`ifdef PC_SEQ_BREAKPOINT_EN
        n_checks++; if (state_o !== 3'd4 || at_bp_o !== 1'b1)
            $display("FAIL bp_enter state=%0d at_bp=%b exp=4/1", state_o, at_bp_o); else n_pass++;
        drive_tick(1'b0);
        e = exp_q.pop_front();
        n_checks++; if (pc_o !== e) $display("FAIL bp_hold got=%0h exp=%0h", pc_o, e); else n_pass++;
        pulse_step();
        drive_tick(1'b1);
        e = exp_q.pop_front();
        n_checks++; if (pc_o !== e || state_o !== 3'd0)
            $display("FAIL bp_step pc=%0h state=%0d exp=%0h/0", pc_o, state_o, e); else n_pass++;
`else
        n_checks++; if (state_o !== 3'd1 || at_bp_o !== 1'b0)
            $display("FAIL bp_disabled state=%0d at_bp=%b exp=1/0", state_o, at_bp_o); else n_pass++;
        do_stop();
`endif
        bp_en_i = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; tick_i = 1'b0; run_i = 1'b0; step_i = 1'b0; stop_i = 1'b0;
        clear_i = 1'b0; halt_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0;
        branch_i = 1'b0; zero_i = 1'b0; br_off_i = '0; bp_addr_i = '0; bp_en_i = 1'b0;
        m_pc = 8'h00; m_ret = '0;
        test_reset();
        test_run();
        test_step();
        test_branch_wrap();
        test_back_to_back();
        test_halt_clear();
        test_stop_tick();
        test_reset_mid_run();
        test_breakpoint();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the single-cycle core; replaces the bare PC register clocked from the divided 1 Hz clock.
- Runs on the full system clock and advances only on a tick enable.
- Adds run, single-step, stop, halt, clear and branch/jump next-PC selection, plus a retired-instruction counter.
- Feeds instruction-memory address and LCD/LED debug displays.

Parameters:
- ADDR_W, 8, PC/address width in bits.
- RESET_ADDR, 0, PC value after reset or clear.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst_n  in  1  asynchronous active-low reset.
- tick_i  in  1  one-clk advance enable (from frequency divider).
- run_i  in  1  level; rising edge requests continuous run.
- step_i  in  1  level; rising edge requests one instruction.
- stop_i  in  1  level; while high, RUN/STEP return to IDLE.
- clear_i  in  1  synchronous clear: PC=RESET_ADDR, counter=0, state IDLE.
- halt_i  in  1  decoded halt instruction at current PC.
- jump_i  in  1  jump taken.
- jump_addr_i  in  ADDR_W  absolute jump target.
- branch_i  in  1  branch instruction.
- zero_i  in  1  ULA zero flag.
- br_off_i  in  ADDR_W  signed branch offset, two's complement.
- bp_addr_i  in  ADDR_W  breakpoint address (macro only).
- bp_en_i  in  1  breakpoint enable (macro only).
- pc_o  out  ADDR_W  current PC.
- pc_plus1_o  out  ADDR_W  pc_o+1, combinational, mod 2^ADDR_W.
- state_o  out  3  encoded FSM state.
- retired_o  out  CNT_W  instructions retired.
- halted_o  out  1  high in HALT.
- at_bp_o  out  1  high in BREAK (tied 0 without macro).

Behaviour:
- Reset (async, rst_n=0):
  - pc_o=RESET_ADDR, retired_o=0, state=IDLE, halted_o=0, at_bp_o=0.
  - Edge-detect registers=0, so an input held high through reset gives no edge.
- Edge detect: run/step edges are registered; an edge acts on the clk after the input rises (1-clk latency).
- next_pc:
  - jump_i gives jump_addr_i.
  - else (branch_i & zero_i) gives pc_plus1 + br_off_i.
  - else pc_plus1.
  - All arithmetic mod 2^ADDR_W, so wrap at the top address is legal.
- Advance = pc<=next_pc and retired+1. retired saturates at all-ones.
- States, encoding IDLE=0, RUN=1, STEP=2, HALT=3, BREAK=4:
  - IDLE: run edge goes to RUN; step edge goes to STEP. Both in the same clk: RUN wins. No advance.
  - RUN: on tick_i, advance; if halt_i instead, no advance and go to HALT. stop_i high goes to IDLE with no advance, even if tick_i is high the same clk.
  - STEP: on next tick_i, advance once and go to IDLE; halt_i at that tick goes to HALT with no advance. stop_i goes to IDLE.
  - HALT: holds PC; exits only via clear_i or reset; run/step ignored.
  - BREAK: run edge goes to RUN; step edge goes to STEP; PC held.
- Priority within a clk: clear_i > stop_i > halt_i > tick advance.
- Reset asserted mid-run: immediate return to reset values; no partial update.
- state_o reflects the registered state.
- halted_o and at_bp_o are registered decodes of state.

Optional Feature:
- Macro PC_SEQ_BREAKPOINT_EN.
- Defined:
  - bp_addr_i and bp_en_i are active.
  - In RUN, an advance whose next_pc == bp_addr_i with bp_en_i=1 still advances, then enters BREAK.
  - STEP ignores breakpoints.
- Undefined:
  - bp ports are present but ignored.
  - BREAK is unreachable; at_bp_o=0.

Decomposition:
- Shared package pc_seq_pkg:
  - state enum/constants: IDLE, RUN, STEP, HALT, BREAK, width 3.
  - default ADDR_W, CNT_W.
- One natural sub-module: edge_detect (registered rising-edge pulse, async active-low reset), instantiated for run_i and step_i.

Test Plan:
- Reset then run edge, 3 ticks, no branch/jump: pc 0→1→2→3, retired=3, state=RUN.
- From IDLE at pc=5, step edge then 2 ticks: pc=6 after first tick only, state back to IDLE, retired=1.
- RUN at pc=0x10, branch_i=1, zero_i=1, br_off_i=0xFC (−4), tick: pc=0x0D. Same with zero_i=0: pc=0x11.
- RUN at pc=0xFF, tick: pc=0x00 (wrap). jump_i=1, jump_addr_i=0x40, tick: pc=0x40.
- RUN with halt_i=1 and tick: pc unchanged, halted_o=1. run edge: stays HALT. clear_i: pc=0, retired=0, IDLE.
- With PC_SEQ_BREAKPOINT_EN, bp_addr_i=0x04, bp_en_i=1: run from 0 → pc=4, at_bp_o=1, state=BREAK. step edge + tick: pc=5, IDLE. stop_i and tick in the same clk in RUN: no advance, IDLE.
